// File: rtl/ps2_ascii_decoder_pkg.sv
// Shared PS/2 set-2 decode definitions: prefix and modifier codes, prefix FSM states
// and the JP-106 scancode-to-ASCII lookup.
package ps2_ascii_decoder_pkg;

  localparam logic [7:0] KB_BRK    = 8'hF0;
  localparam logic [7:0] KB_EXT    = 8'hE0;
  localparam logic [7:0] KB_LSHIFT = 8'h12;
  localparam logic [7:0] KB_RSHIFT = 8'h59;
  localparam logic [7:0] KB_CAPS   = 8'h58;
  localparam logic [7:0] KB_UNDEF  = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BRK     = 2'd1,
    ST_EXT     = 2'd2,
    ST_EXT_BRK = 2'd3
  } kb_state_e;

  // Letters follow shift^caps; everything else is a {shifted, unshifted} pair keyed on shift only.
  function automatic logic [7:0] kb_lookup(input logic [7:0] code, input logic shift,
                                           input logic caps);
    logic [7:0]  lower;
    logic [15:0] sym;
    logic [7:0]  result;
    case (code)
      8'h1C: lower = 8'h61;  8'h32: lower = 8'h62;  8'h21: lower = 8'h63;
      8'h23: lower = 8'h64;  8'h24: lower = 8'h65;  8'h2B: lower = 8'h66;
      8'h34: lower = 8'h67;  8'h33: lower = 8'h68;  8'h43: lower = 8'h69;
      8'h3B: lower = 8'h6A;  8'h42: lower = 8'h6B;  8'h4B: lower = 8'h6C;
      8'h3A: lower = 8'h6D;  8'h31: lower = 8'h6E;  8'h44: lower = 8'h6F;
      8'h4D: lower = 8'h70;  8'h15: lower = 8'h71;  8'h2D: lower = 8'h72;
      8'h1B: lower = 8'h73;  8'h2C: lower = 8'h74;  8'h3C: lower = 8'h75;
      8'h2A: lower = 8'h76;  8'h1D: lower = 8'h77;  8'h22: lower = 8'h78;
      8'h35: lower = 8'h79;  8'h1A: lower = 8'h7A;
      default: lower = 8'h00;
    endcase
    case (code)
      8'h16: sym = {8'h21, 8'h31};  8'h1E: sym = {8'h22, 8'h32};
      8'h26: sym = {8'h23, 8'h33};  8'h25: sym = {8'h24, 8'h34};
      8'h2E: sym = {8'h25, 8'h35};  8'h36: sym = {8'h26, 8'h36};
      8'h3D: sym = {8'h27, 8'h37};  8'h3E: sym = {8'h28, 8'h38};
      8'h46: sym = {8'h29, 8'h39};  8'h45: sym = {8'h30, 8'h30};
      8'h4E: sym = {8'h3D, 8'h2D};  8'h55: sym = {8'h7E, 8'h5E};
      8'h6A: sym = {8'h7C, 8'h5C};  8'h54: sym = {8'h60, 8'h40};
      8'h5B: sym = {8'h7B, 8'h5B};  8'h4C: sym = {8'h2B, 8'h3B};
      8'h52: sym = {8'h2A, 8'h3A};  8'h5D: sym = {8'h7D, 8'h5D};
      8'h41: sym = {8'h3C, 8'h2C};  8'h49: sym = {8'h3E, 8'h2E};
      8'h4A: sym = {8'h3F, 8'h2F};  8'h51: sym = {8'h5F, 8'h5F};
      8'h66: sym = {8'h08, 8'h08};  8'h5A: sym = {8'h0D, 8'h0D};
      8'h29: sym = {8'h20, 8'h20};  8'h76: sym = {8'h1B, 8'h1B};
      default: sym = {KB_UNDEF, KB_UNDEF};
    endcase
    if (lower != 8'h00) begin
      result = (shift ^ caps) ? (lower - 8'h20) : lower;
    end else begin
      result = shift ? sym[15:8] : sym[7:0];
    end
    return result;
  endfunction

endpackage

// File: rtl/ps2_ascii_decoder_sync_fifo.sv
// Synchronous FIFO with occupancy count; simultaneous push and pop on full both succeed.
module ps2_ascii_decoder_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         sclr,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign empty     = (count_r == CW'(0));
  assign full      = (count_r == CW'(DEPTH));
  assign do_pop_s  = pop & ~empty & ~sclr;
  assign do_push_s = push & (~full | do_pop_s) & ~sclr;
  assign head      = empty ? {WIDTH{1'b0}} : mem_r[rd_ptr_r];
  assign count     = count_r;

  // Storage array carries no reset; only written entries are ever read.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (sclr) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      count_r  <= CW'(0);
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/ps2_ascii_decoder.sv
// PS/2 set-2 byte stream to ASCII character FIFO with make/break/extended tracking.
// Optional KB_TYPEMATIC_FILTER_EN suppresses auto-repeat of the last held make code.
module ps2_ascii_decoder
  import ps2_ascii_decoder_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter bit EMIT_UNDEF = 1'b0
) (
  input  logic                        clk,
  input  logic                        i_sclr,
  input  logic                        i_valid,
  input  logic [7:0]                  i_scancode,
  input  logic                        i_ready,
  output logic                        o_valid,
  output logic [7:0]                  o_ascii,
  output logic                        o_shift,
  output logic                        o_capslock,
  output logic [$clog2(DEPTH+1)-1:0]  o_count,
  output logic                        o_overflow
);

  kb_state_e  state_r;
  logic       shift_l_r;
  logic       shift_r_r;
  logic       capslock_r;
  logic       caps_held_r;
  logic       overflow_r;
  logic       shift_s;
  logic       make_push_s;
  logic       repeat_s;
  logic       push_s;
  logic [7:0] push_data_s;
  logic [7:0] lookup_s;
  logic       full_s;
  logic       empty_s;
  logic       pop_s;

  assign shift_s  = shift_l_r | shift_r_r;
  assign lookup_s = kb_lookup(i_scancode, shift_s, capslock_r);
  assign pop_s    = i_ready & ~empty_s;

`ifdef KB_TYPEMATIC_FILTER_EN
  logic [7:0] last_make_r;
  logic       last_live_r;

  assign repeat_s = last_live_r & (i_scancode == last_make_r);

  // Remember the last pushed plain make until its break arrives.
  always_ff @(posedge clk) begin
    if (i_sclr) begin
      last_make_r <= 8'h00;
      last_live_r <= 1'b0;
    end else if (i_valid && state_r == ST_IDLE && make_push_s && !repeat_s) begin
      last_make_r <= i_scancode;
      last_live_r <= 1'b1;
    end else if (i_valid && state_r == ST_BRK && i_scancode == last_make_r) begin
      last_live_r <= 1'b0;
    end else begin
      last_live_r <= last_live_r;
    end
  end
`else
  assign repeat_s = 1'b0;
`endif

  // Decide from current prefix state and byte whether this strobe pushes a character.
  always_comb begin
    make_push_s = 1'b0;
    push_s      = 1'b0;
    push_data_s = 8'h00;
    case (i_scancode)
      KB_BRK, KB_EXT, KB_LSHIFT, KB_RSHIFT, KB_CAPS: make_push_s = 1'b0;
      default: make_push_s = (lookup_s != KB_UNDEF) | EMIT_UNDEF;
    endcase
    if (!i_valid) begin
      push_s = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          push_s      = make_push_s & ~repeat_s;
          push_data_s = lookup_s;
        end
        ST_EXT: begin
          case (i_scancode)
            8'h5A: begin push_s = 1'b1; push_data_s = 8'h0D; end
            8'h4A: begin push_s = 1'b1; push_data_s = 8'h2F; end
            default: begin push_s = 1'b0; push_data_s = 8'h00; end
          endcase
        end
        default: begin
          push_s      = 1'b0;
          push_data_s = 8'h00;
        end
      endcase
    end
  end

  // Prefix FSM plus modifier latches; caps_held blocks caps toggling on typematic repeats.
  always_ff @(posedge clk) begin
    if (i_sclr) begin
      state_r     <= ST_IDLE;
      shift_l_r   <= 1'b0;
      shift_r_r   <= 1'b0;
      capslock_r  <= 1'b0;
      caps_held_r <= 1'b0;
    end else if (i_valid) begin
      case (state_r)
        ST_IDLE: begin
          case (i_scancode)
            KB_BRK:    state_r   <= ST_BRK;
            KB_EXT:    state_r   <= ST_EXT;
            KB_LSHIFT: shift_l_r <= 1'b1;
            KB_RSHIFT: shift_r_r <= 1'b1;
            KB_CAPS: begin
              if (!caps_held_r) capslock_r <= ~capslock_r;
              caps_held_r <= 1'b1;
            end
            default: state_r <= ST_IDLE;
          endcase
        end
        ST_BRK: begin
          case (i_scancode)
            KB_LSHIFT: shift_l_r   <= 1'b0;
            KB_RSHIFT: shift_r_r   <= 1'b0;
            KB_CAPS:   caps_held_r <= 1'b0;
            default:   shift_l_r   <= shift_l_r;
          endcase
          state_r <= ST_IDLE;
        end
        ST_EXT:  state_r <= (i_scancode == KB_BRK) ? ST_EXT_BRK : ST_IDLE;
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // Sticky record of any character lost to a full FIFO.
  always_ff @(posedge clk) begin
    if (i_sclr) begin
      overflow_r <= 1'b0;
    end else if (push_s && full_s && !pop_s) begin
      overflow_r <= 1'b1;
    end else begin
      overflow_r <= overflow_r;
    end
  end

  ps2_ascii_decoder_sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .sclr      (i_sclr),
    .push      (push_s),
    .push_data (push_data_s),
    .pop       (i_ready),
    .head      (o_ascii),
    .full      (full_s),
    .empty     (empty_s),
    .count     (o_count)
  );

  assign o_valid    = ~empty_s;
  assign o_shift    = shift_s;
  assign o_capslock = capslock_r;
  assign o_overflow = overflow_r;

endmodule

// File: tb/tb_ps2_ascii_decoder.sv
// Directed self-checking bench for ps2_ascii_decoder (DEPTH=8, EMIT_UNDEF=0).
module tb_ps2_ascii_decoder;

  localparam int DEPTH = 8;
`ifdef KB_TYPEMATIC_FILTER_EN
  localparam int TM_ENTRIES = 2;
`else
  localparam int TM_ENTRIES = 4;
`endif

  logic       clk = 1'b0;
  logic       i_sclr = 1'b1;
  logic       i_valid = 1'b0;
  logic [7:0] i_scancode = 8'h00;
  logic       i_ready = 1'b0;
  logic       o_valid;
  logic [7:0] o_ascii;
  logic       o_shift;
  logic       o_capslock;
  logic [3:0] o_count;
  logic       o_overflow;

  int errors = 0;
  int checks = 0;

  ps2_ascii_decoder #(.DEPTH(DEPTH), .EMIT_UNDEF(1'b0)) dut (
    .clk        (clk),
    .i_sclr     (i_sclr),
    .i_valid    (i_valid),
    .i_scancode (i_scancode),
    .i_ready    (i_ready),
    .o_valid    (o_valid),
    .o_ascii    (o_ascii),
    .o_shift    (o_shift),
    .o_capslock (o_capslock),
    .o_count    (o_count),
    .o_overflow (o_overflow)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    i_valid    = 1'b1;
    i_scancode = b;
    @(negedge clk);
    i_valid    = 1'b0;
  endtask

  task automatic pop_expect(input string tag, input logic [7:0] exp);
    check_eq({tag, "_valid"}, o_valid, 16'd1);
    check_eq(tag, o_ascii, exp);
    i_ready = 1'b1;
    @(negedge clk);
    i_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    i_sclr = 1'b1;
    @(negedge clk);
    i_sclr = 1'b0;
  endtask

  logic [7:0] drain_exp [8] = '{8'h32, 8'h31, 8'h32, 8'h31, 8'h32, 8'h31, 8'h32, 8'h32};

  initial begin
    repeat (2) @(negedge clk);
    i_sclr = 1'b0;
    check_eq("rst_valid", o_valid, 16'd0);
    check_eq("rst_ascii", o_ascii, 16'h00);
    check_eq("rst_count", o_count, 16'd0);
    check_eq("rst_ovf", o_overflow, 16'd0);
    check_eq("rst_shift", o_shift, 16'd0);
    check_eq("rst_caps", o_capslock, 16'd0);

    // make + break of 'a'
    send(8'h1C); send(8'hF0); send(8'h1C);
    check_eq("mb_count", o_count, 16'd1);
    pop_expect("mb_a", 8'h61);
    check_eq("mb_empty", o_valid, 16'd0);
    i_ready = 1'b1;
    repeat (2) @(negedge clk);
    i_ready = 1'b0;
    check_eq("underflow_count", o_count, 16'd0);
    check_eq("underflow_ascii", o_ascii, 16'h00);

    // shift handling
    do_reset();
    send(8'h12);
    check_eq("shift_on", o_shift, 16'd1);
    send(8'h1C); send(8'h16); send(8'hF0); send(8'h12);
    check_eq("shift_off", o_shift, 16'd0);
    send(8'h1C);
    check_eq("shift_count", o_count, 16'd3);
    pop_expect("shift_A", 8'h41);
    pop_expect("shift_excl", 8'h21);
    pop_expect("shift_a", 8'h61);

    // caps lock with held-key repeat
    do_reset();
    send(8'h58);
    check_eq("caps_on", o_capslock, 16'd1);
    send(8'h58);
    check_eq("caps_repeat", o_capslock, 16'd1);
    send(8'hF0); send(8'h58);
    send(8'h1C);
    send(8'h12); send(8'h1A); send(8'hF0); send(8'h12);
    send(8'h16);
    send(8'h58);
    check_eq("caps_off", o_capslock, 16'd0);
    send(8'hF0); send(8'h58);
    check_eq("caps_count", o_count, 16'd3);
    pop_expect("caps_A", 8'h41);
    pop_expect("caps_shift_z", 8'h7A);
    pop_expect("caps_digit", 8'h31);

    // extended prefix
    do_reset();
    send(8'hE0); send(8'h5A);
    send(8'hE0); send(8'hF0); send(8'h5A);
    send(8'hE0); send(8'h75);
    send(8'hE0); send(8'h4A);
    send(8'h1C);
    check_eq("ext_count", o_count, 16'd3);
    pop_expect("ext_enter", 8'h0D);
    pop_expect("ext_slash", 8'h2F);
    pop_expect("ext_idle_a", 8'h61);

    // fixed keys, shifted symbols, unmapped drop
    do_reset();
    send(8'h12); send(8'h45); send(8'h4E); send(8'hF0); send(8'h12);
    send(8'h0E); send(8'h55);
    check_eq("sym_count", o_count, 16'd3);
    pop_expect("sym_zero", 8'h30);
    pop_expect("sym_eq", 8'h3D);
    pop_expect("sym_caret", 8'h5E);

    // reset mid-prefix and i_valid during reset
    do_reset();
    send(8'hE0);
    @(negedge clk);
    i_sclr = 1'b1; i_valid = 1'b1; i_scancode = 8'h1C;
    @(negedge clk);
    i_sclr = 1'b0; i_valid = 1'b0;
    check_eq("sclr_ignore", o_count, 16'd0);
    send(8'h1C);
    pop_expect("sclr_fresh", 8'h61);

    // fill, overflow, push+pop on full, drain through wrap
    do_reset();
    for (int i = 0; i < DEPTH; i++) send((i % 2 == 0) ? 8'h16 : 8'h1E);
    check_eq("full_count", o_count, 16'd8);
    check_eq("full_noovf", o_overflow, 16'd0);
    send(8'h16);
    check_eq("ovf_count", o_count, 16'd8);
    check_eq("ovf_flag", o_overflow, 16'd1);
    check_eq("ovf_head", o_ascii, 16'h31);
    @(negedge clk);
    i_valid = 1'b1; i_scancode = 8'h1E; i_ready = 1'b1;
    @(negedge clk);
    i_valid = 1'b0; i_ready = 1'b0;
    check_eq("pushpop_count", o_count, 16'd8);
    check_eq("pushpop_ovf", o_overflow, 16'd1);
    for (int i = 0; i < DEPTH; i++) pop_expect($sformatf("drain%0d", i), drain_exp[i]);
    check_eq("drain_empty", o_valid, 16'd0);
    do_reset();
    check_eq("ovf_clear", o_overflow, 16'd0);

    // typematic repeats
    send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C); send(8'h1C);
    check_eq("tm_count", o_count, 16'(TM_ENTRIES));
    for (int i = 0; i < TM_ENTRIES; i++) pop_expect($sformatf("tm%0d", i), 8'h61);
    check_eq("tm_empty", o_valid, 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
